// File: rtl/pbus_arb_if.sv
// Bundle of requester, engine and status signals shared by pbus_arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface pbus_arb_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_rw;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_done;
    logic [DATA_WIDTH-1:0] req0_rdata;

    logic                  req1_valid;
    logic                  req1_rw;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_done;
    logic [DATA_WIDTH-1:0] req1_rdata;

    logic                  eng_load;
    logic                  eng_wr_cmd;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic [DATA_WIDTH-1:0] eng_wdata;
    logic [DATA_WIDTH-1:0] eng_rdata;
    logic                  eng_busy;
    logic                  eng_finish;

    logic                  grant;
    logic                  err;
    logic                  active;

    modport slave (
        input  req0_valid, req0_rw, req0_addr, req0_wdata,
        input  req1_valid, req1_rw, req1_addr, req1_wdata,
        input  eng_rdata, eng_busy, eng_finish,
        output req0_done, req0_rdata, req1_done, req1_rdata,
        output eng_load, eng_wr_cmd, eng_addr, eng_wdata,
        output grant, err, active
    );

    modport master (
        output req0_valid, req0_rw, req0_addr, req0_wdata,
        output req1_valid, req1_rw, req1_addr, req1_wdata,
        output eng_rdata, eng_busy, eng_finish,
        input  req0_done, req0_rdata, req1_done, req1_rdata,
        input  eng_load, eng_wr_cmd, eng_addr, eng_wdata,
        input  grant, err, active
    );
endinterface

// File: rtl/pbus_arbiter.sv
// Two-requester arbiter in front of one parallel-bus engine, with start-timeout detection.
// Define PBUS_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
//
// state        | meaning
// S_IDLE       | wait for a request and an idle engine, latch the winner
// S_ISSUE      | one-cycle eng_load strobe, arm the start timer
// S_WAIT_START | wait for eng_busy, abort on start timeout
// S_WAIT_DONE  | wait for eng_busy to fall, capture read data
// S_RESP       | one-cycle done pulse to the owner
module pbus_arbiter #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    pbus_arb_if.slave   bus
);
`ifdef PBUS_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    localparam logic [15:0] CNT_INIT = 16'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_err;
    logic                  r_active;
    logic                  r_wr_cmd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [15:0]           r_cnt;

    logic w_win;
    logic w_eng_idle;
    logic w_take;
    logic w_load;
    logic w_timeout;
    logic w_capture;
    logic w_done;

    assign w_eng_idle = ~bus.eng_busy & bus.eng_finish;

    // last_grant only steers the choice when both requesters contend and round-robin is built in
    always_comb begin
        w_win = ~bus.req0_valid;
        if (RR_EN && bus.req0_valid && bus.req1_valid) begin
            w_win = ~r_last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((bus.req0_valid || bus.req1_valid) && w_eng_idle) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_load      = 1'b1;
                w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (bus.eng_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == 16'd0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.eng_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_err        <= 1'b0;
            r_active     <= 1'b0;
            r_wr_cmd     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_take) begin
                r_grant  <= w_win;
                r_wr_cmd <= w_win ? bus.req1_rw    : bus.req0_rw;
                r_addr   <= w_win ? bus.req1_addr  : bus.req0_addr;
                r_wdata  <= w_win ? bus.req1_wdata : bus.req0_wdata;
                r_active <= 1'b1;
            end
            // down-counter: terminal count 0 means START_TIMEOUT idle cycles have elapsed
            if (w_load) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == S_WAIT_START && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_capture && r_wr_cmd) begin
                if (r_grant) begin
                    r_rdata1 <= bus.eng_rdata;
                end else begin
                    r_rdata0 <= bus.eng_rdata;
                end
            end
            if (w_done) begin
                r_last_grant <= r_grant;
                r_active     <= 1'b0;
            end
        end
    end

    assign bus.eng_load   = w_load;
    assign bus.eng_wr_cmd = r_wr_cmd;
    assign bus.eng_addr   = r_addr;
    assign bus.eng_wdata  = r_wdata;
    assign bus.req0_done  = w_done & ~r_grant;
    assign bus.req1_done  = w_done & r_grant;
    assign bus.req0_rdata = r_rdata0;
    assign bus.req1_rdata = r_rdata1;
    assign bus.grant      = r_grant;
    assign bus.err        = r_err;
    assign bus.active     = r_active;
endmodule

// File: tb/tb_pbus_arbiter.sv
// Bench for pbus_arbiter: behavioural engine model, transaction-level reference model, directed and random steps.
module tb_pbus_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pbus_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_TIMEOUT(ST)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // engine model state
    logic          e_busy = 1'b0;
    logic          e_hang = 1'b0;
    logic          fin_hold = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic [DW-1:0] e_rdval = '0;
    int            e_start_dly = 1;
    int            e_busy_len = 1;

    assign bus.eng_busy   = e_busy;
    assign bus.eng_finish = ~e_busy & ~fin_hold;
    assign bus.eng_rdata  = e_rdata;

    int            cyc = 0;
    int            n_loads = 0;
    int            ld_cyc = 0;
    logic          ld_cmd = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    int            n_done0 = 0;
    int            n_done1 = 0;

    // reference model
    logic [DW-1:0] m_rdata [2];
    logic          m_last;
    logic          m_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.req0_done === 1'b1) n_done0 <= n_done0 + 1;
        if (bus.req1_done === 1'b1) n_done1 <= n_done1 + 1;
    end

    always begin
        @(negedge clk);
        if (bus.eng_load === 1'b1) begin
            n_loads++;
            ld_cyc   = cyc;
            ld_cmd   = bus.eng_wr_cmd;
            ld_addr  = bus.eng_addr;
            ld_wdata = bus.eng_wdata;
            if (!e_hang) begin
                repeat (e_start_dly) @(posedge clk);
                #1 e_busy = 1'b1;
                repeat (e_busy_len) @(posedge clk);
                #1 e_busy = 1'b0;
                e_rdata = e_rdval;
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input logic v0, input logic v1, input logic last);
`ifdef PBUS_ARB_RR_EN
        if (v0 && v1) return ~last;
`endif
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic model_reset();
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_last     = 1'b1;
        m_err      = 1'b0;
    endtask

    task automatic drive_req(input int r, input logic v, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_rw = rw; bus.req0_addr = a; bus.req0_wdata = wd;
        end else begin
            bus.req1_valid = v; bus.req1_rw = rw; bus.req1_addr = a; bus.req1_wdata = wd;
        end
    endtask

    task automatic wait_done(output int who, output logic g, output logic [DW-1:0] r0, output logic [DW-1:0] r1,
                             output logic er, output int dc);
        who = -1; g = 1'b0; r0 = '0; r1 = '0; er = 1'b0; dc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req0_done === 1'b1 || bus.req1_done === 1'b1) begin
                who = (bus.req0_done && bus.req1_done) ? 2 : (bus.req1_done ? 1 : 0);
                g   = bus.grant;
                r0  = bus.req0_rdata;
                r1  = bus.req1_rdata;
                er  = bus.err;
                dc  = cyc;
                break;
            end
        end
        chk("done_seen", longint'(who >= 0), 1);
    endtask

    task automatic xfer(input int r, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rv, input int dly, input int blen, input logic hang, input int hold);
        int            l0, d0, d1, who, dc;
        logic          g, er;
        logic [DW-1:0] r0, r1;
        l0 = n_loads; d0 = n_done0; d1 = n_done1;
        e_rdval = rv; e_start_dly = dly; e_busy_len = blen; e_hang = hang;
        if (hold > 0) fin_hold = 1'b1;
        drive_req(r, 1'b1, rw, a, wd);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_no_load", n_loads - l0, 0);
            chk("hold_inactive", bus.active, 0);
            fin_hold = 1'b0;
        end
        wait_done(who, g, r0, r1, er, dc);
        @(posedge clk);
        #1 drive_req(r, 1'b0, rw, a, wd);
        if (!hang && rw) m_rdata[r] = rv;
        if (hang) m_err = 1'b1;
        m_last = r[0];
        chk("owner", who, r);
        chk("grant", g, r);
        chk("rdata0", r0, m_rdata[0]);
        chk("rdata1", r1, m_rdata[1]);
        chk("err", er, m_err);
        chk("load_count", n_loads - l0, 1);
        chk("load_cmd", ld_cmd, rw);
        chk("load_addr", ld_addr, a);
        chk("load_wdata", ld_wdata, wd);
        chk("latency", dc - ld_cyc, hang ? ST + 1 : dly + blen + 1);
        chk("done_own", (r == 1) ? n_done1 - d1 : n_done0 - d0, 1);
        chk("done_other", (r == 1) ? n_done0 - d0 : n_done1 - d1, 0);
        chk("active_after", bus.active, 0);
    endtask

    initial begin
        int            l0, d0, d1, who, dc;
        logic          g, er, exp_g;
        logic [DW-1:0] r0, r1;

        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        model_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {bus.eng_load, bus.eng_wr_cmd, bus.eng_addr, bus.eng_wdata, bus.grant, bus.err, bus.active,
                            bus.req0_done, bus.req1_done, bus.req0_rdata, bus.req1_rdata}, 0);
        chk("rst_active", bus.active, 0);
        rst = 1'b1;

        xfer(0, 1'b0, 8'h12, 8'hA5, 8'h77, 1, 6, 1'b0, 0);
        xfer(1, 1'b1, 8'h40, 8'h00, 8'h3C, 1, 6, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(1, 3), $urandom_range(1, 5), 1'b0, 0);
        end

        xfer(0, 1'b1, 8'h21, 8'h00, 8'h9D, 1, 2, 1'b0, 6);

        xfer(0, 1'b1, 8'h55, 8'h66, 8'hEE, 1, 1, 1'b1, 0);
        xfer(1, 1'b1, 8'h56, 8'h00, 8'hC3, 2, 3, 1'b0, 0);

        // reset while the engine is mid-transfer
        e_hang = 1'b0; e_start_dly = 1; e_busy_len = 8; e_rdval = 8'h5A;
        l0 = n_loads;
        drive_req(0, 1'b1, 1'b1, 8'h33, 8'h00);
        for (int i = 0; i < 20 && n_loads == l0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_loaded", n_loads - l0, 1);
        repeat (2) @(posedge clk);
        #1;
        d0 = n_done0; d1 = n_done1;
        rst = 1'b0;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        chk("midrst_outputs", {bus.eng_load, bus.eng_wr_cmd, bus.eng_addr, bus.eng_wdata, bus.grant, bus.err, bus.active,
                               bus.req0_done, bus.req1_done, bus.req0_rdata, bus.req1_rdata}, 0);
        chk("midrst_err", bus.err, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_done", (n_done0 - d0) + (n_done1 - d1), 0);
        chk("midrst_no_load", n_loads - l0, 1);
        chk("midrst_inactive", bus.active, 0);

        // contention: both requesters held valid across four transfers
        e_start_dly = 1; e_busy_len = 2;
        drive_req(0, 1'b1, 1'b0, 8'h10, 8'h01);
        drive_req(1, 1'b1, 1'b0, 8'h20, 8'h02);
        for (int i = 0; i < 4; i++) begin
            wait_done(who, g, r0, r1, er, dc);
            exp_g = pick(1'b1, 1'b1, m_last);
            chk("cont_grant", g, exp_g);
            chk("cont_owner", who, exp_g);
            chk("cont_addr", ld_addr, exp_g ? 8'h20 : 8'h10);
            m_last = exp_g;
        end
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        chk("cont_rdata0", bus.req0_rdata, m_rdata[0]);
        chk("cont_rdata1", bus.req1_rdata, m_rdata[1]);

        xfer(1, 1'b1, 8'h7E, 8'h00, 8'h81, 1, 1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pbus_arbiter.md
Name: pbus_arbiter

Overview:
- Shares one parallel-bus write/read engine between two requesters: req0 is the configuration sequencer, req1 is the host command path.
- Arbitrates between them and issues one transfer at a time to the engine through its load/busy/finish handshake.
- Returns read data and a one-cycle done pulse to the requester that owns the transfer.
- Detects an engine that never starts a transfer and reports it on err.

Parameters:
ADDR_WIDTH, 8, address width of requests and of eng_addr
DATA_WIDTH, 8, data width of wdata/rdata paths
START_TIMEOUT, 16, cycles to wait for eng_busy after eng_load before aborting (valid range 1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req0_valid  in  1  req0 transfer request; held high until req0_done
req0_rw  in  1  0 = write, 1 = read
req0_addr  in  ADDR_WIDTH  req0 address
req0_wdata  in  DATA_WIDTH  req0 write data
req0_done  out  1  one-cycle completion pulse to req0
req0_rdata  out  DATA_WIDTH  read data for req0; valid when req0_done is high, then held
req1_valid, req1_rw, req1_addr, req1_wdata, req1_done, req1_rdata  same as the req0 ports, for req1
eng_load  out  1  one-cycle load strobe to the engine
eng_wr_cmd  out  1  0 = write, 1 = read
eng_addr  out  ADDR_WIDTH  registered address
eng_wdata  out  DATA_WIDTH  registered write data
eng_rdata  in  DATA_WIDTH  engine read data, valid once eng_busy falls
eng_busy  in  1  engine busy
eng_finish  in  1  engine idle/finished
grant  out  1  owner of the current transfer: 0 = req0, 1 = req1
err  out  1  sticky start-timeout flag
active  out  1  high from the grant cycle until the done pulse, inclusive

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE; all outputs 0; last_grant = 1, so req0 wins first under round-robin.
  - A reset during any transfer abandons it: no done pulse is issued.
  - The engine is not reset by this block.
- IDLE:
  - Waits for at least one reqN_valid and for eng_busy = 0 with eng_finish = 1.
  - Picks a winner (see Optional Feature) and registers grant, eng_addr, eng_wdata and eng_wr_cmd from the winner.
  - Sets active = 1 and goes to ISSUE.
- ISSUE:
  - eng_load = 1 for exactly one cycle; timeout counter cleared.
  - Goes to WAIT_START.
- WAIT_START:
  - Counter increments each cycle.
  - eng_busy = 1: go to WAIT_DONE.
  - Counter reaches START_TIMEOUT with eng_busy still 0: set err = 1, pulse reqN_done for the owner with reqN_rdata unchanged, clear active, return to IDLE.
- WAIT_DONE:
  - Waits for eng_busy = 0.
  - On that cycle, for a read, captures eng_rdata into the owner's reqN_rdata; for a write, reqN_rdata is unchanged.
  - Goes to RESP.
- RESP:
  - reqN_done = 1 for one cycle for the owner only.
  - Updates last_grant = grant, clears active, goes to IDLE.
- Latency:
  - Best case, from valid sampled in IDLE to done: 1 (IDLE) + 1 (ISSUE) + engine start latency + engine busy time + 1 (RESP).
  - Request fields are sampled only in the IDLE grant cycle. Changes afterwards are ignored.
- Requester contract:
  - Deassert reqN_valid in the cycle after reqN_done.
  - If valid stays high, it is treated as a new request.
- Simultaneous requests: only one is granted; the other waits with no loss.
- A request arriving while active waits for the return to IDLE.
- err clears only on reset.
- The unknown-state default goes to IDLE.

Optional Feature:
- Macro: PBUS_ARB_RR_EN.
- Defined (round-robin):
  - When both requesters are valid, grant goes to the one that is not last_grant.
  - A single valid requester always wins.
- Undefined (fixed priority):
  - req0 always wins over req1.
  - last_grant is still maintained but does not affect arbitration.

Test Plan:
- Single write: req0 write addr 0x12, data 0xA5; engine model asserts busy 1 cycle after load for 6 cycles -> eng_load pulses once with eng_wr_cmd = 0, eng_addr = 0x12, eng_wdata = 0xA5; req0_done pulses once; grant = 0.
- Single read: req1 read addr 0x40; model returns 0x3C when busy falls -> req1_rdata = 0x3C at req1_done; req0_rdata unchanged; req0_done never pulses.
- Contention: req0 and req1 both valid continuously for 4 transfers -> with PBUS_ARB_RR_EN, grant sequence 0,1,0,1; without it, 0,0,0,0 while req0 stays valid.
- Timeout: model never asserts busy, START_TIMEOUT = 4 -> err = 1 about 4 cycles after eng_load; owner's done pulses; state back in IDLE; next request is served normally.
- Engine not idle: eng_finish = 0 while req0 is valid -> no eng_load until eng_finish = 1 and eng_busy = 0.
- Reset mid-transfer: rst = 0 during WAIT_DONE -> all outputs 0 next cycle; no done pulse; err = 0.
